// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter sharing one slave; grant held for the whole cyc.
// Optional strobe timeout: define WB_ARB_TIMEOUT_EN to enable TIMEOUT_CYCLES error pulses.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   granted_stb;
  logic   timeout;

  // Derived from the masters directly so the timeout path does not loop through s_stb_o.
  assign granted_stb = ((state == GRANT0) && m0_stb_i) || ((state == GRANT1) && m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic [CW:0]   wait_inc;

  // Error fires on the cycle that would bring the wait count to TIMEOUT_CYCLES.
  assign wait_inc = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
  assign timeout  = granted_stb && !s_ack_i && (wait_inc == (CW+1)'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state_nxt == IDLE) || s_ack_i)
      wait_cnt <= '0;
    else if (granted_stb)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0: if (!m0_cyc_i || timeout) state_nxt = IDLE;
      GRANT1: if (!m1_cyc_i || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state)
      GRANT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i && m0_stb_i && !timeout;
        m0_err_o = timeout;
      end
      GRANT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i && m1_stb_i && !timeout;
        m1_err_o = timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized + directed bench for wb_arbiter2 against an owner/round-robin reference model.
module tb_wb_arbiter2;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic        cyc [2];
  logic        stb [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [3:0]  s_sel_o;

  int n_checks = 0;
  int n_pass   = 0;
  int owner    = -1;
  int last_g   = 1;
  int waits    = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Timeout fires on the TMO-th consecutive unacknowledged strobe cycle of the owner.
  function automatic logic exp_err();
`ifdef WB_ARB_TIMEOUT_EN
    if (owner < 0) return 1'b0;
    return stb[owner] && !s_ack_i && (waits + 1 == TMO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    logic [31:0] ea = '0, ed = '0, ed0 = '0, ed1 = '0;
    logic [3:0]  es = '0;
    logic ewe = 1'b0, ecyc = 1'b0, estb = 1'b0;
    logic ea0 = 1'b0, ea1 = 1'b0, ee0 = 1'b0, ee1 = 1'b0;
    logic e;
    e = exp_err();
    if (owner >= 0) begin
      ea = adr[owner]; ed = wdat[owner]; ewe = we[owner]; es = sel[owner];
      ecyc = cyc[owner]; estb = stb[owner];
      if (owner == 0) begin ea0 = s_ack_i && stb[0] && !e; ed0 = s_dat_i; ee0 = e; end
      else            begin ea1 = s_ack_i && stb[1] && !e; ed1 = s_dat_i; ee1 = e; end
    end
    check("s_adr", s_adr_o, ea);   check("s_dat", s_dat_o, ed);
    check("s_we", s_we_o, ewe);    check("s_sel", s_sel_o, es);
    check("s_cyc", s_cyc_o, ecyc); check("s_stb", s_stb_o, estb);
    check("m0_ack", m0_ack_o, ea0); check("m0_dat", m0_dat_o, ed0); check("m0_err", m0_err_o, ee0);
    check("m1_ack", m1_ack_o, ea1); check("m1_dat", m1_dat_o, ed1); check("m1_err", m1_err_o, ee1);
  endtask

  task automatic model_edge();
    logic e;
    int   nxt;
    e   = exp_err();
    nxt = owner;
    if (rst) begin
      owner = -1; last_g = 1; waits = 0;
    end else begin
      if (owner < 0) begin
        if (cyc[0] && cyc[1]) nxt = 1 - last_g;
        else if (cyc[0])      nxt = 0;
        else if (cyc[1])      nxt = 1;
        if (nxt >= 0) last_g = nxt;
      end else if (!cyc[owner] || e) begin
        nxt = -1;
      end
      if (nxt < 0 || s_ack_i)          waits = 0;
      else if (owner >= 0 && stb[owner]) waits = waits + 1;
      owner = nxt;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; wdat[m] = '0; we[m] = 1'b0; sel[m] = '0; cyc[m] = 1'b0; stb[m] = 1'b0;
    end
    s_dat_i = '0; s_ack_i = 1'b0;
  endtask

  task automatic random_cycles(input int n, input int ack_pct);
    for (int i = 0; i < n; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) cyc[m] = ($urandom_range(2) == 0);
        else if ($urandom_range(4) == 0) cyc[m] = 1'b0;
        stb[m]  = cyc[m] && ($urandom_range(3) != 0);
        adr[m]  = $urandom; wdat[m] = $urandom;
        we[m]   = 1'($urandom_range(1)); sel[m] = 4'($urandom_range(15));
      end
      s_ack_i = ($urandom_range(99) < ack_pct);
      s_dat_i = $urandom;
      rst     = ($urandom_range(99) == 0);
      at_neg();
      edge_step();
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    edge_step();
    at_neg();
    check("reset_cyc", s_cyc_o, 32'h0);
    edge_step();
    rst = 1'b0;

    // single read by m0, slave acks on the granted cycle
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0400_0010; sel[0] = 4'hF;
    at_neg(); edge_step();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_BABE;
    at_neg();
    check("rd_ack", m0_ack_o, 32'h1);
    check("rd_dat", m0_dat_o, 32'hCAFE_BABE);
    check("rd_m1", {m1_ack_o, m1_dat_o != 32'h0}, 32'h0);
    edge_step();
    clear_inputs();
    at_neg(); edge_step();

    // simultaneous request: m0 first, one idle cycle, then m1
    rst = 1'b1; at_neg(); edge_step(); rst = 1'b0;
    adr[0] = 32'h100; adr[1] = 32'h200;
    cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b1;
    at_neg(); edge_step();
    at_neg(); check("tie_g0", s_adr_o, 32'h100); edge_step();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    at_neg(); edge_step();
    at_neg(); check("tie_idle", s_cyc_o, 32'h0); edge_step();
    at_neg(); check("tie_g1", s_adr_o, 32'h200); edge_step();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    at_neg(); edge_step();

    // round robin alternation with both masters requesting
    for (int k = 0; k < 4; k++) begin
      cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b1; s_ack_i = 1'b1;
      at_neg(); edge_step();
      at_neg(); check("rr_grant", {m1_ack_o, m0_ack_o}, (k % 2) ? 32'h2 : 32'h1); edge_step();
      cyc[k % 2] = 1'b0; stb[k % 2] = 1'b0;
      at_neg(); edge_step();
    end
    clear_inputs();
    at_neg(); edge_step();

    // m1 burst of four writes while m0 waits
    cyc[1] = 1'b1;
    at_neg(); edge_step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100;
    for (int b = 1; b <= 4; b++) begin
      we[1] = 1'b1; sel[1] = 4'hF; wdat[1] = 32'(b); stb[1] = 1'b1; s_ack_i = 1'b1;
      at_neg();
      check("burst_dat", s_dat_o, 32'(b));
      check("burst_m0ack", m0_ack_o, 32'h0);
      edge_step();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack_i = 1'b0;
    at_neg(); edge_step();
    at_neg(); check("burst_idle", s_cyc_o, 32'h0); edge_step();
    at_neg(); check("burst_m0", s_adr_o, 32'h100); edge_step();
    clear_inputs();
    at_neg(); edge_step();

    // reset in the middle of a GRANT1 strobe
    cyc[1] = 1'b1; stb[1] = 1'b1; s_ack_i = 1'b1;
    at_neg(); edge_step();
    at_neg(); check("rst_pre", s_cyc_o, 32'h1);
    rst = 1'b1; edge_step(); rst = 1'b0;
    at_neg();
    check("rst_cyc", s_cyc_o, 32'h0);
    check("rst_ack", m1_ack_o, 32'h0);
    edge_step();
    clear_inputs();
    at_neg(); edge_step();

    // hung slave: error pulse only with the timeout build
    cyc[0] = 1'b1; stb[0] = 1'b1;
    at_neg(); edge_step();
    for (int w = 1; w <= 12; w++) begin
      at_neg();
`ifdef WB_ARB_TIMEOUT_EN
      check("tmo_err", m0_err_o, (w == TMO) ? 32'h1 : 32'h0);
`else
      check("tmo_err", m0_err_o, 32'h0);
      check("tmo_hold", s_cyc_o, 32'h1);
`endif
      edge_step();
    end
    clear_inputs();
    at_neg(); edge_step();

    random_cycles(2000, 50);
    random_cycles(1000, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
